mem_stage: RTL
==============

# mem_stage

EX/MEM pipeline register plus data-memory access controller for the five-stage MIPS pipeline. Latches the execute-stage results (ALU result, store data, control bits) on the hazard unit's advance enable. It drives the data-cache request and holds it until `dhit`, asserting `mem_stall` while the access is outstanding. It then presents the selected write-back value and control to the MEM/WB latch, and forwarding taps to the forwarding unit.

## Interface
Parameters:
- none (widths come from `cpu_types_pkg`: `word_t` 32, `regbits_t` 5)

Ports:
- `CLK`  in  1  system clock, rising edge
- `nRST`  in  1  asynchronous active-low reset
- `memen`  in  1  advance enable: capture execute outputs at this edge
- `flush`  in  1  insert bubble at this edge; priority over `memen`
- `ALUOut`, `dmemstore`, `nPC`, `lui`  in  32 each  execute-stage results
- `dREN`, `dWEN`, `regWr`, `halt`  in  1 each  execute-stage control
- `regSel`  in  3  write-back source select
- `regDst`  in  5  destination register
- `dhit`  in  1  data cache access done
- `dmemload`  in  32  cache read data, valid with `dhit`
- `dmemREN`, `dmemWEN`  out  1 each  cache request
- `dmemaddr`, `dmemstore_out`  out  32 each  request address / write data
- `mem_stall`  out  1  to hazard unit: stage cannot advance
- `wbData`  out  32  value to write back
- `regWr_out`, `halt_out`  out  1 each
- `regDst_out`  out  5
- `fwdValid`  out  1  forwarding tap valid (macro-gated)
- `fwdReg`  out  5  forwarding tap register (macro-gated)
- `fwdData`  out  32  forwarding tap value (macro-gated)

## Operation
- Edge priority, in order:
  - `flush`: bubble, meaning all latched control = 0, data = 0, state IDLE; any outstanding request dropped.
  - `memen`: capture all inputs; state ← REQ if `dREN|dWEN`, else IDLE.
  - otherwise: hold.
- FSM:
  - IDLE: no request.
  - REQ: `dmemREN` = latched `dREN`, `dmemWEN` = latched `dWEN`, `dmemaddr` = latched `ALUOut`. On `dhit`, capture `dmemload` into load buffer. Next state: DONE if `memen`=0, else per the capture rule above.
  - DONE: access complete; request low; hold until next `memen`/`flush`.
- `mem_stall` = (state==REQ) & ~`dhit`, combinational.
- `dREN` and `dWEN` both set: treat as write only (`dmemREN` forced 0).
- `wbData` select by `regSel`: 0 `ALUOut`; 1 load data; 2 `nPC`; 3 `lui`; 4–7 `ALUOut`.
- Load data source: `dmemload` when REQ & `dhit`; load buffer in DONE.
- `halt_out` sticky: set when a latched `halt`=1; cleared only by reset.
- `regWr_out`, `regDst_out` pass latched values; bubble gives `regWr_out`=0.

## Timing
- Reset (async, `nRST`=0): state IDLE; every output 0; load buffer 0; `halt_out` 0.
- Latency: inputs are visible on outputs one cycle after the `memen` edge.
- A memory request is asserted for at least one full cycle. It stays asserted through the cycle `dhit` rises and drops at the following edge.
- `dhit` in the first REQ cycle gives zero stall cycles.
- `dhit` and `memen` on the same edge: the next instruction is latched and the load value goes downstream that edge.
- `flush` during REQ: the request is abandoned. The hazard unit does not flush this latch while `mem_stall`=1 except on a branch redirect.
- `dhit` seen in IDLE or DONE: ignored.

## Configuration
- `MEMSTAGE_FWD_EN` defined:
  - `fwdValid` = latched `regWr` & (`regDst`≠0) & ~`mem_stall`
  - `fwdReg` = `regDst_out`
  - `fwdData` = `wbData`
- Undefined: all three tied 0 and the forwarding unit resolves hazards by stalling.

## Structure
- `cpu_types_pkg` holds:
  - `word_t`, `regbits_t`
  - enum `memstate_t` {IDLE, REQ, DONE}
  - `regSel` encodings `WB_ALU`=0, `WB_LOAD`=1, `WB_NPC`=2, `WB_LUI`=3
- Interface `mem_if` (modport `mem`) mirrors the port list.
- One sub-module, `mem_req_fsm`: the state register, request and stall generation, and the load buffer. The top module holds the latch and the `wbData` mux.

## Test plan
- Reset mid-REQ (`dREN`=1, `dhit`=0, drop `nRST`) → all outputs 0 immediately, state IDLE.
- Load, `ALUOut`=0x100, `regSel`=1, `dhit` after 3 cycles → `dmemREN`=1 and `dmemaddr`=0x100 for 3 cycles; `mem_stall`=1 for 2 cycles, 0 on the `dhit` cycle; `wbData`=`dmemload`=0xDEADBEEF.
- Store with `dhit` in the first cycle and `memen`=1 → `dmemWEN`=1 for one cycle, `dmemstore_out`=0x1234, `mem_stall` never high, next instruction latched.
- Load `dhit` while `memen`=0 for 2 cycles → DONE, request low, `wbData` holds buffered 0xCAFEF00D.
- `flush` and `memen` on the same edge with `regWr`=1 → `regWr_out`=0, no request.
- `halt`=1 latched, then further instructions → `halt_out` stays 1; with `MEMSTAGE_FWD_EN`, an ALU op with `regDst`=8 gives `fwdValid`=1, `fwdReg`=8, `fwdData`=`ALUOut`.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath widths, memory-stage FSM states and
// write-back source encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;
    typedef logic [2:0]  regsel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memstate_t;

    localparam regsel_t WB_ALU  = 3'd0;
    localparam regsel_t WB_LOAD = 3'd1;
    localparam regsel_t WB_NPC  = 3'd2;
    localparam regsel_t WB_LUI  = 3'd3;

endpackage

// File: rtl/mem_if.sv
// Bundle of the memory-stage signals; the mem modport is the stage's view.
interface mem_if;
    import cpu_types_pkg::*;

    logic     memen, flush;
    word_t    ALUOut, dmemstore, nPC, lui;
    logic     dREN, dWEN, regWr, halt;
    regsel_t  regSel;
    regbits_t regDst;
    logic     dhit;
    word_t    dmemload;
    logic     dmemREN, dmemWEN;
    word_t    dmemaddr, dmemstore_out;
    logic     mem_stall;
    word_t    wbData;
    logic     regWr_out, halt_out;
    regbits_t regDst_out;
    logic     fwdValid;
    regbits_t fwdReg;
    word_t    fwdData;

    modport mem (
        input  memen, flush, ALUOut, dmemstore, nPC, lui, dREN, dWEN, regWr,
               halt, regSel, regDst, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore_out, mem_stall, wbData,
               regWr_out, halt_out, regDst_out, fwdValid, fwdReg, fwdData
    );
endinterface

// File: rtl/mem_req_fsm.sv
// Data-cache request sequencer: IDLE/REQ/DONE state, request strobes,
// stall generation and the buffer that keeps load data after dhit.
module mem_req_fsm
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  logic  memen,
    input  logic  req_start,   // incoming instruction accesses memory
    input  logic  dren_lat,
    input  logic  dwen_lat,
    input  logic  dhit,
    input  word_t dmemload,
    output logic  req_active,
    output logic  dmemREN,
    output logic  dmemWEN,
    output logic  mem_stall,
    output word_t load_data
);

    memstate_t state_reg, state_next;
    word_t     loadbuf_reg, loadbuf_next;

    // State and load buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            loadbuf_reg <= '0;
        end else begin
            state_reg   <= state_next;
            loadbuf_reg <= loadbuf_next;
        end
    end

    // Next state: flush beats memen, memen beats completion; dhit outside REQ is ignored
    always_comb begin
        state_next   = state_reg;
        loadbuf_next = loadbuf_reg;
        if (flush) begin
            state_next   = IDLE;
            loadbuf_next = '0;
        end else begin
            if (state_reg == REQ && dhit)
                loadbuf_next = dmemload;
            if (memen)
                state_next = req_start ? REQ : IDLE;
            else if (state_reg == REQ && dhit)
                state_next = DONE;
        end
    end

    // Request strobes; a simultaneous read+write is issued as a write only
    always_comb begin
        req_active = (state_reg == REQ);
        dmemWEN    = req_active & dwen_lat;
        dmemREN    = req_active & dren_lat & ~dwen_lat;
        mem_stall  = req_active & ~dhit;
        load_data  = '0;
        if (req_active && dhit)
            load_data = dmemload;
        else if (state_reg == DONE)
            load_data = loadbuf_reg;
    end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM pipeline latch and data-memory access stage.
// Optional forwarding taps are enabled by defining MEMSTAGE_FWD_EN.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     memen,
    input  logic     flush,
    input  word_t    ALUOut,
    input  word_t    dmemstore,
    input  word_t    nPC,
    input  word_t    lui,
    input  logic     dREN,
    input  logic     dWEN,
    input  logic     regWr,
    input  logic     halt,
    input  regsel_t  regSel,
    input  regbits_t regDst,
    input  logic     dhit,
    input  word_t    dmemload,
    output logic     dmemREN,
    output logic     dmemWEN,
    output word_t    dmemaddr,
    output word_t    dmemstore_out,
    output logic     mem_stall,
    output word_t    wbData,
    output logic     regWr_out,
    output logic     halt_out,
    output regbits_t regDst_out,
    output logic     fwdValid,
    output regbits_t fwdReg,
    output word_t    fwdData
);

    word_t    alu_reg, store_reg, npc_reg, lui_reg;
    logic     dren_reg, dwen_reg, regwr_reg, halt_reg;
    regsel_t  regsel_reg;
    regbits_t regdst_reg;
    logic     req_active;
    word_t    load_data;

    // EX/MEM latch: flush inserts a bubble, memen captures, otherwise hold
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            alu_reg    <= '0;
            store_reg  <= '0;
            npc_reg    <= '0;
            lui_reg    <= '0;
            dren_reg   <= 1'b0;
            dwen_reg   <= 1'b0;
            regwr_reg  <= 1'b0;
            regsel_reg <= WB_ALU;
            regdst_reg <= '0;
        end else if (flush) begin
            alu_reg    <= '0;
            store_reg  <= '0;
            npc_reg    <= '0;
            lui_reg    <= '0;
            dren_reg   <= 1'b0;
            dwen_reg   <= 1'b0;
            regwr_reg  <= 1'b0;
            regsel_reg <= WB_ALU;
            regdst_reg <= '0;
        end else if (memen) begin
            alu_reg    <= ALUOut;
            store_reg  <= dmemstore;
            npc_reg    <= nPC;
            lui_reg    <= lui;
            dren_reg   <= dREN;
            dwen_reg   <= dWEN;
            regwr_reg  <= regWr;
            regsel_reg <= regSel;
            regdst_reg <= regDst;
        end
    end

    // Halt is sticky once a halting instruction is latched; only reset clears it
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            halt_reg <= 1'b0;
        else if (!flush && memen && halt)
            halt_reg <= 1'b1;
    end

    mem_req_fsm u_req_fsm (
        .clk        (CLK),
        .rst_n      (nRST),
        .flush      (flush),
        .memen      (memen),
        .req_start  (dREN | dWEN),
        .dren_lat   (dren_reg),
        .dwen_lat   (dwen_reg),
        .dhit       (dhit),
        .dmemload   (dmemload),
        .req_active (req_active),
        .dmemREN    (dmemREN),
        .dmemWEN    (dmemWEN),
        .mem_stall  (mem_stall),
        .load_data  (load_data)
    );

    // Address and store data are only driven while a request is outstanding
    always_comb begin
        dmemaddr      = req_active ? alu_reg   : '0;
        dmemstore_out = req_active ? store_reg : '0;
    end

    // Write-back source select; unused encodings fall back to the ALU result
    always_comb begin
        case (regsel_reg)
            WB_ALU:  wbData = alu_reg;
            WB_LOAD: wbData = load_data;
            WB_NPC:  wbData = npc_reg;
            WB_LUI:  wbData = lui_reg;
            default: wbData = alu_reg;
        endcase
    end

    assign regWr_out  = regwr_reg;
    assign regDst_out = regdst_reg;
    assign halt_out   = halt_reg;

`ifdef MEMSTAGE_FWD_EN
    // Forwarding tap is only trustworthy once the access has completed
    always_comb begin
        fwdValid = regwr_reg & (regdst_reg != '0) & ~mem_stall;
        fwdReg   = regdst_reg;
        fwdData  = wbData;
    end
`else
    // Without taps the forwarding unit must stall on every hazard
    always_comb begin
        fwdValid = 1'b0;
        fwdReg   = '0;
        fwdData  = '0;
    end
`endif

endmodule
